// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the single-master bus fabric:
//   - state_e     : fabric FSM states (IDLE / ACCESS / RESP)
//   - HB_*        : access-size encodings carried on i_M_HB / o_S_HB
//   - BUS_DW      : bus data and address width
//   - DEF_SEL_*   : default position and width of the slave-select address field
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int BUS_DW = 32;

  localparam int DEF_SEL_LSB = 28;
  localparam int DEF_SEL_W   = 4;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/bus_decode.sv
// -----------------------------------------------------------------------------
// bus_decode
// Combinational slave-select decode. The caller hands in the slave-select
// field of the address; this block turns it into a one-hot slave vector and
// flags selects that do not name an existing slave.
//
// Parameters:
//   N_SLAVES : number of slave ports (1..16)
//   SEL_W    : width of the slave-select field
// Ports:
//   i_sel     in  SEL_W     slave-select field taken from the address
//   o_sel_oh  out N_SLAVES  one-hot slave vector (all zero on a decode error)
//   o_dec_err out 1         select value >= N_SLAVES
// -----------------------------------------------------------------------------
module bus_decode
  import bus_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int SEL_W    = DEF_SEL_W
) (
  input  logic [SEL_W-1:0]    i_sel,
  output logic [N_SLAVES-1:0] o_sel_oh,
  output logic                o_dec_err
);

  // One extra bit so that N_SLAVES == 2**SEL_W still fits in the compare.
  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_SLAVES);

  always_comb begin
    o_sel_oh = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      o_sel_oh[k] = (i_sel == SEL_W'(k));
    end
    o_dec_err = ({1'b0, i_sel} >= N_LIM);
  end

endmodule

// File: rtl/bus_fabric.sv
// -----------------------------------------------------------------------------
// bus_fabric
// Single-master to N-slave bus fabric. A master request is latched in IDLE,
// decoded to one slave, presented to that slave in ACCESS until it grants,
// and completed with a one-cycle o_M_GNT pulse in RESP.
//
// Handshake: the master raises i_M_REQ and holds it (with stable request
// fields) until it sees o_M_GNT; o_M_GNT is a single-cycle completion pulse
// and o_M_RDATA / o_M_ERR are meaningful only in that cycle. Toward a slave,
// o_S_CE[sel] and o_S_REQ stay high until i_S_GNT[sel] is seen; grant bits
// of non-selected slaves are ignored. If i_M_REQ is still high in the cycle
// after the pulse, that is a new transaction.
//
// Optional feature: define BUS_FABRIC_TIMEOUT_EN to bound the ACCESS wait to
// TIMEOUT_CYC cycles; expiry completes the transfer with o_M_ERR=1. Without
// the macro ACCESS waits for a grant indefinitely.
//
// Parameters: N_SLAVES (1..16), SEL_LSB, SEL_W, TIMEOUT_CYC (1..65535)
// Ports:
//   i_CLK, i_RSTn                  clock, asynchronous active-low reset
//   i_M_REQ/ADDR/WDATA/WE/RE/HB    master request
//   o_M_GNT/RDATA/ERR              master completion
//   o_S_CE                         one-hot slave chip enable
//   o_S_REQ/WE/RE/HB/ADDR/WDATA    latched request toward the slaves
//   i_S_GNT, i_S_RDATA             per-slave grant and read data (32 bits each)
//   o_dbg_state                    current FSM state (state_e encoding)
// -----------------------------------------------------------------------------
module bus_fabric
  import bus_pkg::*;
#(
  parameter int N_SLAVES    = 4,
  parameter int SEL_LSB     = DEF_SEL_LSB,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       i_CLK,
  input  logic                       i_RSTn,
  input  logic                       i_M_REQ,
  input  logic [BUS_DW-1:0]          i_M_ADDR,
  input  logic [BUS_DW-1:0]          i_M_WDATA,
  input  logic                       i_M_WE,
  input  logic                       i_M_RE,
  input  logic [1:0]                 i_M_HB,
  output logic                       o_M_GNT,
  output logic [BUS_DW-1:0]          o_M_RDATA,
  output logic                       o_M_ERR,
  output logic [N_SLAVES-1:0]        o_S_CE,
  output logic                       o_S_REQ,
  output logic                       o_S_WE,
  output logic                       o_S_RE,
  output logic [1:0]                 o_S_HB,
  output logic [BUS_DW-1:0]          o_S_ADDR,
  output logic [BUS_DW-1:0]          o_S_WDATA,
  input  logic [N_SLAVES-1:0]        i_S_GNT,
  input  logic [BUS_DW*N_SLAVES-1:0] i_S_RDATA,
  output logic [1:0]                 o_dbg_state
);

  // Elaboration-time parameter range guards.
  if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_n_slaves
    $error("bus_fabric: N_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("bus_fabric: TIMEOUT_CYC must be 1..65535");
  end

  state_e                state_q, state_d;
  logic [BUS_DW-1:0]     addr_q, addr_d;
  logic [BUS_DW-1:0]     wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [1:0]            hb_q, hb_d;
  logic [N_SLAVES-1:0]   sel_oh_q, sel_oh_d;
  logic [BUS_DW-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

`ifdef BUS_FABRIC_TIMEOUT_EN
  // Value held in the last ACCESS cycle that may still wait for a grant.
  localparam logic [15:0] TMO_TERM = 16'(TIMEOUT_CYC - 1);
  logic [15:0]           tmo_q, tmo_d;
`endif

  logic [SEL_W-1:0]      sel_field;
  logic [N_SLAVES-1:0]   dec_oh;
  logic                  dec_err;
  logic                  gnt_hit;
  logic [BUS_DW-1:0]     rd_mux;

  assign sel_field = i_M_ADDR[SEL_LSB +: SEL_W];

  bus_decode #(
    .N_SLAVES (N_SLAVES),
    .SEL_W    (SEL_W)
  ) u_decode (
    .i_sel     (sel_field),
    .o_sel_oh  (dec_oh),
    .o_dec_err (dec_err)
  );

  // Masking with the latched one-hot means stray grants from other slaves
  // can never complete the transfer.
  assign gnt_hit = |(i_S_GNT & sel_oh_q);

  // AND-OR read mux keyed by the latched one-hot select.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_oh_q[k]) begin
        rd_mux = rd_mux | i_S_RDATA[k*BUS_DW +: BUS_DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    re_d     = re_q;
    hb_d     = hb_q;
    sel_oh_d = sel_oh_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef BUS_FABRIC_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (i_M_REQ) begin
          addr_d   = i_M_ADDR;
          wdata_d  = i_M_WDATA;
          // A simultaneous read+write request is treated as a write.
          we_d     = i_M_WE;
          re_d     = i_M_RE & ~i_M_WE;
          hb_d     = i_M_HB;
          sel_oh_d = dec_oh;
          if (dec_err) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
`ifdef BUS_FABRIC_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      ST_ACCESS: begin
        // Grant is checked first so a grant on the terminal count wins.
        if (gnt_hit) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = re_q ? rd_mux : '0;
        end
`ifdef BUS_FABRIC_TIMEOUT_EN
        else if (tmo_q == TMO_TERM) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      hb_q     <= '0;
      sel_oh_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef BUS_FABRIC_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      hb_q     <= hb_d;
      sel_oh_q <= sel_oh_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef BUS_FABRIC_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  // Master-side results exist only in RESP; slave strobes only in ACCESS.
  assign o_M_GNT     = (state_q == ST_RESP);
  assign o_M_ERR     = (state_q == ST_RESP) & err_q;
  assign o_M_RDATA   = (state_q == ST_RESP) ? rdata_q : '0;
  assign o_S_CE      = (state_q == ST_ACCESS) ? sel_oh_q : '0;
  assign o_S_REQ     = (state_q == ST_ACCESS);
  assign o_S_WE      = we_q;
  assign o_S_RE      = re_q;
  assign o_S_HB      = hb_q;
  assign o_S_ADDR    = addr_q;
  assign o_S_WDATA   = wdata_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bus_fabric.sv
// -----------------------------------------------------------------------------
// tb_bus_fabric
// Self-checking bench for bus_fabric (N_SLAVES=4, SEL_LSB=28, SEL_W=4,
// TIMEOUT_CYC=8). Honours BUS_FABRIC_TIMEOUT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_bus_fabric;

  localparam int N   = 4;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         m_req, m_we, m_re;
  logic [31:0]  m_addr, m_wdata;
  logic [1:0]   m_hb;
  logic         m_gnt, m_err;
  logic [31:0]  m_rdata;
  logic [N-1:0] s_ce, s_gnt;
  logic         s_req, s_we, s_re;
  logic [1:0]   s_hb;
  logic [31:0]  s_addr, s_wdata;
  logic [127:0] s_rdata;
  logic [1:0]   dbg_state;

  logic [31:0]  slave_data [N];
  assign s_rdata = {slave_data[3], slave_data[2], slave_data[1], slave_data[0]};

  bus_fabric #(
    .N_SLAVES    (N),
    .SEL_LSB     (28),
    .SEL_W       (4),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_CLK       (clk),
    .i_RSTn      (rst_n),
    .i_M_REQ     (m_req),
    .i_M_ADDR    (m_addr),
    .i_M_WDATA   (m_wdata),
    .i_M_WE      (m_we),
    .i_M_RE      (m_re),
    .i_M_HB      (m_hb),
    .o_M_GNT     (m_gnt),
    .o_M_RDATA   (m_rdata),
    .o_M_ERR     (m_err),
    .o_S_CE      (s_ce),
    .o_S_REQ     (s_req),
    .o_S_WE      (s_we),
    .o_S_RE      (s_re),
    .o_S_HB      (s_hb),
    .o_S_ADDR    (s_addr),
    .o_S_WDATA   (s_wdata),
    .i_S_GNT     (s_gnt),
    .i_S_RDATA   (s_rdata),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];   // {err, rdata} expected at each completion pulse

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Completion cycle is counted from the request-sampling cycle (cycle 0).
  function automatic void model(input logic [31:0] addr, input logic we, input logic re,
                                input int gnt_k, output int cyc, output logic err,
                                output logic [31:0] rd, output logic [3:0] ce);
    int sel;
    sel = int'(addr[31:28]);
    if (sel >= N) begin
      cyc = 1; err = 1'b1; rd = 32'h0; ce = 4'b0;
    end else begin
      ce  = 4'(1 << sel);
      cyc = gnt_k + 1;
      err = 1'b0;
      rd  = (re && !we) ? slave_data[sel] : 32'h0;
`ifdef BUS_FABRIC_TIMEOUT_EN
      if (gnt_k > TMO) begin
        cyc = TMO + 1; err = 1'b1; rd = 32'h0;
      end
`endif
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      m_req  = 1'b0;
      m_addr = $urandom;
      m_we   = 1'($urandom_range(0, 1));
      m_re   = 1'($urandom_range(0, 1));
      s_gnt  = 4'($urandom);
      @(negedge clk);
      chk("idle gnt",   {63'd0, m_gnt}, 64'd0);
      chk("idle ce",    {60'd0, s_ce},  64'd0);
      chk("idle sreq",  {63'd0, s_req}, 64'd0);
      chk("idle rdata", {32'd0, m_rdata}, 64'd0);
    end
  endtask

  // One full transaction: request presented in cycle 0, slave grant driven
  // in cycle gnt_k, completion expected in cycle exp_cyc.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic re, input logic [1:0] hb,
                         input int gnt_k, input bit stray, input int exp_cyc,
                         input logic exp_err, input logic [31:0] exp_rd, input logic [3:0] exp_ce);
    logic exp_we, exp_re;
    logic [32:0] e;
    exp_we = we;
    exp_re = re & ~we;
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk); #1;
    m_req = 1'b1; m_addr = addr; m_wdata = wdata; m_we = we; m_re = re; m_hb = hb;
    s_gnt = stray ? 4'($urandom) : 4'b0;
    @(negedge clk);
    chk({tag, " c0 ce"},  {60'd0, s_ce},  64'd0);
    chk({tag, " c0 gnt"}, {63'd0, m_gnt}, 64'd0);
    for (int c = 1; c <= exp_cyc; c++) begin
      @(posedge clk); #1;
      // Request pins change freely here; they must be ignored outside IDLE.
      m_addr  = $urandom;
      m_wdata = $urandom;
      m_we    = 1'($urandom_range(0, 1));
      m_re    = 1'($urandom_range(0, 1));
      m_hb    = 2'($urandom_range(0, 3));
      s_gnt   = stray ? (4'($urandom) & ~exp_ce) : 4'b0;
      if (c == gnt_k) s_gnt = s_gnt | exp_ce;
      @(negedge clk);
      if (c < exp_cyc) begin
        chk({tag, " ce"},    {60'd0, s_ce},    {60'd0, exp_ce});
        chk({tag, " sreq"},  {63'd0, s_req},   64'd1);
        chk({tag, " gnt"},   {63'd0, m_gnt},   64'd0);
        chk({tag, " err"},   {63'd0, m_err},   64'd0);
        chk({tag, " rdata"}, {32'd0, m_rdata}, 64'd0);
        chk({tag, " saddr"}, {32'd0, s_addr},  {32'd0, addr});
        chk({tag, " swdat"}, {32'd0, s_wdata}, {32'd0, wdata});
        chk({tag, " swe"},   {63'd0, s_we},    {63'd0, exp_we});
        chk({tag, " sre"},   {63'd0, s_re},    {63'd0, exp_re});
        chk({tag, " shb"},   {62'd0, s_hb},    {62'd0, hb});
      end else begin
        e = exp_q.pop_front();
        chk({tag, " gnt"},   {63'd0, m_gnt},   64'd1);
        chk({tag, " err"},   {63'd0, m_err},   {63'd0, e[32]});
        chk({tag, " rdata"}, {32'd0, m_rdata}, {32'd0, e[31:0]});
        chk({tag, " ce@g"},  {60'd0, s_ce},    64'd0);
        chk({tag, " sreq@g"},{63'd0, s_req},   64'd0);
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [1:0]  hb;
    int          gnt_k;
    bit          stray;
    int          idle_after;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_ce;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          cyc;
    logic        err;
    logic [31:0] rd;
    logic [3:0]  ce;
    logic [31:0] a;
    int          k;

    m_req = 1'b0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_re = 1'b0; m_hb = '0;
    s_gnt = '0;
    slave_data[0] = 32'hA0A0_0000;
    slave_data[1] = 32'hDEAD_BEEF;
    slave_data[2] = 32'h2222_2222;
    slave_data[3] = 32'h3333_3333;

    vecs.push_back('{"read s1",    32'h1000_0004, 32'h0,         1'b0, 1'b1, 2'b10, 3, 1'b0, 1, 4, 1'b0, 32'hDEAD_BEEF, 4'b0010});
    vecs.push_back('{"write s2",   32'h2000_0000, 32'h1234_5678, 1'b1, 1'b0, 2'b10, 2, 1'b1, 1, 3, 1'b0, 32'h0,         4'b0100});
    vecs.push_back('{"dec err 7",  32'h7000_0000, 32'h0,         1'b0, 1'b1, 2'b10, 1, 1'b1, 1, 1, 1'b1, 32'h0,         4'b0000});
    vecs.push_back('{"we+re s3",   32'h3000_0010, 32'hCAFE_F00D, 1'b1, 1'b1, 2'b00, 1, 1'b0, 2, 2, 1'b0, 32'h0,         4'b1000});
    vecs.push_back('{"read s0",    32'h0FFF_FFFC, 32'h0,         1'b0, 1'b1, 2'b01, 5, 1'b1, 0, 6, 1'b0, 32'hA0A0_0000, 4'b0001});
    vecs.push_back('{"b2b s3 k8",  32'h3ABC_0000, 32'h0,         1'b0, 1'b1, 2'b10, 8, 1'b1, 0, 9, 1'b0, 32'h3333_3333, 4'b1000});
    vecs.push_back('{"b2b dec F",  32'hF000_0000, 32'h5555_AAAA, 1'b1, 1'b0, 2'b00, 1, 1'b0, 0, 1, 1'b1, 32'h0,         4'b0000});
    vecs.push_back('{"no rw s2",   32'h2000_0000, 32'h0,         1'b0, 1'b0, 2'b10, 1, 1'b0, 1, 2, 1'b0, 32'h0,         4'b0100});

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst gnt",   {63'd0, m_gnt},   64'd0);
    chk("rst err",   {63'd0, m_err},   64'd0);
    chk("rst rdata", {32'd0, m_rdata}, 64'd0);
    chk("rst ce",    {60'd0, s_ce},    64'd0);
    chk("rst sreq",  {63'd0, s_req},   64'd0);
    chk("rst saddr", {32'd0, s_addr},  64'd0);
    chk("rst swdat", {32'd0, s_wdata}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      run_txn(vecs[i].tag, vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re, vecs[i].hb,
              vecs[i].gnt_k, vecs[i].stray, vecs[i].exp_cyc, vecs[i].exp_err,
              vecs[i].exp_rd, vecs[i].exp_ce);
      if (vecs[i].idle_after > 0) idle(vecs[i].idle_after);
    end

    // ---- long wait on a slave ----
`ifdef BUS_FABRIC_TIMEOUT_EN
    run_txn("timeout",    32'h2000_0000, 32'h0, 1'b0, 1'b1, 2'b10, 1000, 1'b1, 9, 1'b1, 32'h0, 4'b0100);
    idle(1);
    run_txn("late gnt k9", 32'h1000_0000, 32'h0, 1'b0, 1'b1, 2'b10, 9, 1'b0, 9, 1'b1, 32'h0, 4'b0010);
    idle(1);
`else
    run_txn("long wait",  32'h2000_0000, 32'h0, 1'b0, 1'b1, 2'b10, 300, 1'b1, 301, 1'b0, 32'h2222_2222, 4'b0100);
    idle(1);
`endif

    // ---- reset during ACCESS ----
    @(posedge clk); #1;
    m_req = 1'b1; m_addr = 32'h1000_0000; m_we = 1'b0; m_re = 1'b1; m_hb = 2'b10; s_gnt = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsta ce c1", {60'd0, s_ce}, 64'h2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    s_gnt = 4'b0010;
    #1;
    chk("rsta ce",    {60'd0, s_ce},   64'd0);
    chk("rsta sreq",  {63'd0, s_req},  64'd0);
    chk("rsta gnt",   {63'd0, m_gnt},  64'd0);
    chk("rsta saddr", {32'd0, s_addr}, 64'd0);
    chk("rsta sre",   {63'd0, s_re},   64'd0);
    m_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rsta hold gnt", {63'd0, m_gnt}, 64'd0);
    end
    rst_n = 1'b1;
    s_gnt = '0;
    idle(2);

    // ---- randomized transactions against the model ----
    for (int t = 0; t < 40; t++) begin
      for (int s = 0; s < N; s++) slave_data[s] = $urandom;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[31:28] = 4'($urandom_range(4, 15));
      else                           a[31:28] = 4'($urandom_range(0, 3));
      k = $urandom_range(1, 12);
      m_we = 1'($urandom_range(0, 1));
      m_re = 1'($urandom_range(0, 1));
      begin
        logic we_r, re_r;
        logic [31:0] wd_r;
        logic [1:0]  hb_r;
        we_r = m_we; re_r = m_re; wd_r = $urandom; hb_r = 2'($urandom_range(0, 2));
        model(a, we_r, re_r, k, cyc, err, rd, ce);
        run_txn($sformatf("rnd%0d", t), a, wd_r, we_r, re_r, hb_r, k,
                bit'($urandom_range(0, 1)), cyc, err, rd, ce);
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    chk("exp_q drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 N_SLAVES, 4, number of slave ports (1..16).
REQ-002 SEL_LSB, 28, lowest address bit of the slave-select field.
REQ-003 SEL_W, 4, width of the slave-select field, ADDR[SEL_LSB+SEL_W-1:SEL_LSB].
REQ-004 TIMEOUT_CYC, 255, maximum wait for a slave grant, in cycles (1..65535).
REQ-005 i_CLK  in  1  single clock; all logic rising-edge.
REQ-006 i_RSTn  in  1  reset; asynchronous, active-low.
REQ-007 i_M_REQ  in  1  master request; held high until o_M_GNT.
REQ-008 i_M_ADDR  in  32  master address.
REQ-009 i_M_WDATA  in  32  master write data.
REQ-010 i_M_WE  in  1  write enable.
REQ-011 i_M_RE  in  1  read enable.
REQ-012 i_M_HB  in  2  access size, passed through to the slave.
REQ-013 o_M_GNT  out  1  one-cycle completion pulse.
REQ-014 o_M_RDATA  out  32  read data; valid only with o_M_GNT.
REQ-015 o_M_ERR  out  1  error flag; valid only with o_M_GNT.
REQ-016 o_S_CE  out  N_SLAVES  one-hot slave chip enable.
REQ-017 o_S_REQ, o_S_WE, o_S_RE, o_S_HB, o_S_ADDR, o_S_WDATA  out  1/1/1/2/32/32  registered copies of the latched master request.
REQ-018 i_S_GNT  in  N_SLAVES  per-slave grant.
REQ-019 i_S_RDATA  in  32*N_SLAVES  per-slave read data; slave k occupies bits [32k+31:32k].

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-021 IDLE with i_M_REQ=1: the block SHALL latch ADDR, WDATA, WE, RE and HB, and decode sel = ADDR[SEL_LSB+SEL_W-1:SEL_LSB].
- If sel < N_SLAVES, the next state SHALL be ACCESS.
- Otherwise, the next state SHALL be RESP with ERR=1.
REQ-022 If both WE and RE are high, the block SHALL latch WE=1 and RE=0.
REQ-023 In ACCESS, o_S_CE[sel]=1 and o_S_REQ=1; all other o_S_CE bits SHALL be 0.
REQ-024 In ACCESS, only i_S_GNT[sel] SHALL be honoured; other grant bits SHALL be ignored.
REQ-025 When i_S_GNT[sel]=1, the block SHALL capture i_S_RDATA slice sel into o_M_RDATA (0 for writes) and go to RESP with ERR=0.
REQ-026 RESP SHALL last exactly one cycle with o_M_GNT=1 and o_M_ERR set as latched, then return to IDLE.
REQ-027 Latency: REQ sampled at cycle 0, CE first high at cycle 1, slave grant at cycle k gives o_M_GNT at cycle k+1.
REQ-028 A decode error SHALL produce o_M_GNT=1, o_M_ERR=1 and o_M_RDATA=0 at cycle 1.
REQ-029 i_M_REQ still high in the cycle after RESP SHALL be treated as a new transaction.
REQ-030 Request inputs SHALL be ignored outside IDLE.
REQ-031 Outside ACCESS, o_S_CE=0 and o_S_REQ=0.
REQ-032 o_M_GNT, o_M_ERR and o_M_RDATA SHALL be 0 outside RESP.

Reset
REQ-033 Reset SHALL asynchronously force IDLE, all outputs to 0, the timeout counter to 0 and the latched request to 0.
REQ-034 A reset asserted during ACCESS SHALL abort the transfer with no o_M_GNT pulse.

Configuration
REQ-035 With BUS_FABRIC_TIMEOUT_EN defined:
- A counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without grant.
- When it reaches TIMEOUT_CYC, the block SHALL go to RESP with ERR=1 and o_M_RDATA=0, dropping CE/REQ.
- A grant arriving in the same cycle as the terminal count SHALL win (ERR=0).
REQ-036 Without BUS_FABRIC_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait for a grant indefinitely.

Structure
REQ-037 A shared package bus_pkg SHALL hold:
- the state enum;
- the HB encodings (byte, half, word);
- the bus data width constant (32);
- the default SEL_LSB/SEL_W constants.
REQ-038 One sub-module, bus_decode, SHALL be natural: combinational address-to-one-hot decode with a decode-error flag.
REQ-039 The FSM, latches, timeout counter and read mux SHALL reside in bus_fabric.

Verification
REQ-040 Read: ADDR=0x1000_0004, RE=1, slave 1 grants at cycle 3 with RDATA=0xDEADBEEF -> o_S_CE=4'b0010 in cycles 1-3; o_M_GNT=1 with RDATA=0xDEADBEEF and ERR=0 at cycle 4.
REQ-041 Write: ADDR=0x2000_0000, WDATA=0x12345678, WE=1, HB=2'b10 -> o_S_WDATA/o_S_HB match; o_M_RDATA=0 at GNT.
REQ-042 Decode error: ADDR=0x7000_0000 with N_SLAVES=4 -> no CE asserted; GNT=1 and ERR=1 at cycle 1.
REQ-043 Timeout (macro on, TIMEOUT_CYC=8): slave never grants -> GNT=1 and ERR=1 at cycle 9; a grant at cycle 8 instead gives ERR=0.
REQ-044 Reset during ACCESS: i_RSTn low at cycle 2 -> CE/REQ=0 immediately, no GNT, IDLE after release.
REQ-045 Back-to-back: REQ held across GNT -> second transaction's CE rises one cycle after RESP; stray i_S_GNT on a non-selected slave has no effect.
